// File: rtl/fir_mc_engine.sv
// Time-multiplexed multi-channel FIR engine. One shared multiply-accumulator walks every
// tap of every channel of an accepted frame, one MAC per clock, then publishes the whole
// frame at once. Coefficients are runtime-loadable and shared by all channels.
//
// Ports:
//   ck         clock
//   rst_n      asynchronous active-low reset
//   in_valid   input frame valid
//   in_ready   engine idle and able to accept a frame
//   in_data    N_CH signed samples, channel c at [c*DW +: DW]
//   bypass     sampled at accept; 1 = output the latched samples unfiltered
//   out_valid  one-cycle pulse when out_data carries a new frame
//   out_data   N_CH signed results, held until the next out_valid
//   coef_we    coefficient write strobe (honoured only while idle)
//   coef_addr  tap index for the write
//   coef_data  signed coefficient value
//   busy       high whenever the engine is not idle
module fir_mc_engine #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned NTAPS = 16,
  parameter int unsigned N_CH  = 2,
  parameter int unsigned SHIFT = 15
) (
  input  logic                      ck,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*DW-1:0]        in_data,
  input  logic                      bypass,
  output logic                      out_valid,
  output logic [N_CH*DW-1:0]        out_data,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic                      busy
);

  localparam int unsigned AW   = $clog2(NTAPS);
  localparam int unsigned CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW   = CW + DW;
  localparam int unsigned AccW = PW + AW;

  localparam logic [AW-1:0]         KLast    = AW'(NTAPS - 1);
  localparam logic [AW-1:0]         NTapsA   = AW'(NTAPS);
  localparam logic [CHW-1:0]        ChLast   = CHW'(N_CH - 1);
  localparam logic signed [CW-1:0]  MaxCoef  = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [AccW:0]  RndConst = (AccW+1)'(1) << (SHIFT - 1);
  localparam logic signed [AccW:0]  MaxV     = {{(AccW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AccW:0]  MinV     = {{(AccW+2-DW){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StMac, StDone} state_e;

  state_e state_q, state_d;

  logic [N_CH*DW-1:0]       in_q;
  logic                     byp_q;
  logic [AW-1:0]            wp_q;
  logic [AW-1:0]            k_q;
  logic [CHW-1:0]           ch_q;
  logic signed [AccW-1:0]   acc_q;
  logic                     out_valid_q;
  logic [N_CH*DW-1:0]       out_data_q;
  logic signed [DW-1:0]     res_q  [N_CH];
  logic signed [DW-1:0]     dly_q  [N_CH][NTAPS];
  logic signed [CW-1:0]     coef_q [NTAPS];

  logic [AW-1:0]            rd_idx;
  logic signed [PW-1:0]     prod;
  logic signed [AccW-1:0]   acc_sum;
  logic signed [AccW:0]     acc_ext;
  logic signed [AccW:0]     rnd_sum;
  logic signed [AccW:0]     shifted;
  logic signed [DW-1:0]     sat;
  logic                     coef_wr;
  logic                     mac_last;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign mac_last = (k_q == KLast) && (ch_q == ChLast);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = StLoad;
      end
      StLoad:  state_d = StMac;
      StMac:   if (mac_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // Tap k reads the sample written k frames ago: (wp - k) mod NTAPS. When wp < k the
    // AW-bit sum wraps back into range even if NTAPS is not a power of two.
    if (wp_q >= k_q) rd_idx = wp_q - k_q;
    else             rd_idx = wp_q - k_q + NTapsA;

    prod    = coef_q[k_q] * dly_q[ch_q][rd_idx];
    acc_sum = acc_q + {{AW{prod[PW-1]}}, prod};

    // Round half-up, arithmetic shift, then clamp to the signed DW-bit range.
    acc_ext = {acc_sum[AccW-1], acc_sum};
    rnd_sum = acc_ext + RndConst;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > MaxV)      sat = MaxV[DW-1:0];
    else if (shifted < MinV) sat = MinV[DW-1:0];
    else                     sat = shifted[DW-1:0];
  end

  assign coef_wr = coef_we && (state_q == StIdle) && (32'(coef_addr) < NTAPS);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      in_q        <= '0;
      byp_q       <= 1'b0;
      wp_q        <= '0;
      k_q         <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        res_q[c] <= '0;
        for (int t = 0; t < NTAPS; t++) dly_q[c][t] <= '0;
      end
      // Near-identity filter out of reset.
      for (int t = 0; t < NTAPS; t++) coef_q[t] <= (t == 0) ? MaxCoef : '0;
    end else begin
      out_valid_q <= 1'b0;
      if (coef_wr) coef_q[coef_addr] <= coef_data;

      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_q  <= in_data;
            byp_q <= bypass;
          end
        end
        StLoad: begin
          // Bypassed frames still enter the delay line so later frames see them.
          for (int c = 0; c < N_CH; c++) dly_q[c][wp_q] <= in_q[c*DW +: DW];
          acc_q <= '0;
          k_q   <= '0;
          ch_q  <= '0;
        end
        StMac: begin
          if (k_q == KLast) begin
            res_q[ch_q] <= sat;
            acc_q       <= '0;
            k_q         <= '0;
            ch_q        <= ch_q + 1'b1;
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + 1'b1;
          end
        end
        StDone: begin
          out_valid_q <= 1'b1;
          for (int c = 0; c < N_CH; c++) begin
            out_data_q[c*DW +: DW] <= byp_q ? in_q[c*DW +: DW] : res_q[c];
          end
          wp_q <= (wp_q == KLast) ? '0 : wp_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mc_engine.sv
// Self-checking bench for fir_mc_engine (defaults: DW=CW=16, NTAPS=16, N_CH=2, SHIFT=15).
// A frame-level arithmetic model (coefficient array, per-channel history, write pointer)
// predicts every output frame.
module tb_fir_mc_engine;

  logic        ck;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        bypass;
  logic        out_valid;
  logic [31:0] out_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_coef [16];
  longint m_dly  [2][16];
  int     m_wp;

  fir_mc_engine dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) m_coef[k] = 0;
    m_coef[0] = 32767;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 16; k++) m_dly[c][k] = 0;
    m_wp = 0;
  endfunction

  // y = clamp(round(sum_k coef[k] * x[n-k] / 2^15)), history shared across bypassed frames.
  function automatic logic [31:0] model_frame(input logic [31:0] d, input logic b);
    logic [31:0] r;
    longint      acc;
    longint      v;
    r = '0;
    for (int c = 0; c < 2; c++) m_dly[c][m_wp] = longint'($signed(d[c*16 +: 16]));
    for (int c = 0; c < 2; c++) begin
      acc = 0;
      for (int k = 0; k < 16; k++) acc += m_coef[k] * m_dly[c][(m_wp - k + 16) % 16];
      v = (acc + 16384) >>> 15;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      r[c*16 +: 16] = v[15:0];
    end
    m_wp = (m_wp + 1) % 16;
    return b ? d : r;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    @(negedge ck);
    rst_n = 1'b0;
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
    @(negedge ck);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge ck);
    #1;
    coef_we = 1'b0;
    m_coef[a] = longint'($signed(d));
  endtask

  // Offers one frame (optionally with a coincident coefficient write), then waits for the
  // output pulse. lat counts clock edges from the accepting edge to out_valid.
  task automatic send_frame(input logic [31:0] d, input logic b, input logic we,
                            input logic [3:0] a, input logic [15:0] cd,
                            output int lat, output logic [31:0] got);
    int guard;
    guard = 0;
    @(negedge ck);
    while (!in_ready && guard < 100) begin
      @(negedge ck);
      guard++;
    end
    in_valid  = 1'b1;
    in_data   = d;
    bypass    = b;
    coef_we   = we;
    coef_addr = a;
    coef_data = cd;
    @(posedge ck);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge ck);
      lat++;
      @(negedge ck);
      if (out_valid) break;
    end
    got = out_data;
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL frame_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic test_identity();
    int          lat;
    logic [31:0] got;
    logic [31:0] exp;
    exp = model_frame({16'hFC18, 16'd1000}, 1'b0);
    send_frame({16'hFC18, 16'd1000}, 1'b0, 1'b0, 4'd0, 16'd0, lat, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL identity_data: got %h required %h", got, exp);
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL identity_latency: got %0d required 34", lat);
    end
  endtask

  task automatic test_reset();
    int          pulses;
    int          lat;
    logic [31:0] got;
    logic [31:0] exp;
    @(negedge ck);
    in_valid = 1'b1;
    in_data  = $urandom;
    bypass   = 1'b0;
    @(posedge ck);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ck);
    @(negedge ck);
    rst_n = 1'b0;
    @(negedge ck);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_out_data: got %h required 00000000", out_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    rst_n = 1'b1;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_aborted_frame: got %0d pulses required 0", pulses);
    end
    // Coefficients and history must be back at their reset values.
    in_data = $urandom;
    exp = model_frame(in_data, 1'b0);
    send_frame(in_data, 1'b0, 1'b0, 4'd0, 16'd0, lat, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_coef_default: got %h required %h", got, exp);
    end
  endtask

  task automatic test_impulse();
    int          lat;
    logic [31:0] got;
    logic [31:0] exp;
    logic [31:0] d;
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k[3:0], 16'(k + 1));
    for (int f = 0; f < 16; f++) begin
      d = {16'($urandom), (f == 0) ? 16'h7FFF : 16'h0000};
      exp = model_frame(d, 1'b0);
      send_frame(d, 1'b0, 1'b0, 4'd0, 16'd0, lat, got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL impulse_frame%0d: got %h required %h", f, got, exp);
      end
      checks++;
      if (got[15:0] !== 16'(f + 1)) begin
        errors++;
        $display("FAIL impulse_ch0_%0d: got %0d required %0d", f, got[15:0], f + 1);
      end
    end
  endtask

  task automatic test_saturation();
    int          lat;
    logic [31:0] got;
    logic [31:0] exp;
    for (int k = 0; k < 16; k++) write_coef(k[3:0], 16'h7FFF);
    for (int f = 0; f < 16; f++) begin
      exp = model_frame({16'h8000, 16'h7FFF}, 1'b0);
      send_frame({16'h8000, 16'h7FFF}, 1'b0, 1'b0, 4'd0, 16'd0, lat, got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL saturation_frame%0d: got %h required %h", f, got, exp);
      end
    end
    checks++;
    if (got !== 32'h8000_7FFF) begin
      errors++;
      $display("FAIL saturation_final: got %h required 80007fff", got);
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] got;
    logic [31:0] exp;
    logic [31:0] d;
    logic        b;
    logic        we;
    logic [3:0]  a;
    logic [15:0] cd;
    for (int k = 0; k < 16; k++) write_coef(k[3:0], 16'($urandom_range(0, 4095)) - 16'd2048);
    for (int f = 0; f < 24; f++) begin
      d  = $urandom;
      b  = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 4) == 0);
      a  = 4'($urandom_range(0, 15));
      cd = 16'($urandom_range(0, 4095)) - 16'd2048;
      // A write that coincides with the accept is used by that very frame.
      if (we) m_coef[a] = longint'($signed(cd));
      exp = model_frame(d, b);
      send_frame(d, b, we, a, cd, lat, got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_frame%0d: got %h required %h (bypass=%0b we=%0b)",
                 f, got, exp, b, we);
      end
    end
  endtask

  task automatic test_bypass();
    int          lat;
    logic [31:0] got;
    logic [31:0] exp;
    logic [31:0] d;
    d = {16'($urandom), 16'h1234};
    exp = model_frame(d, 1'b1);
    send_frame(d, 1'b1, 1'b0, 4'd0, 16'd0, lat, got);
    checks++;
    if (got !== d) begin
      errors++;
      $display("FAIL bypass_data: got %h required %h", got, d);
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL bypass_latency: got %0d required 34", lat);
    end
    d = $urandom;
    exp = model_frame(d, 1'b0);
    send_frame(d, 1'b0, 1'b0, 4'd0, 16'd0, lat, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bypass_followup: got %h required %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int          n_acc;
    int          acc_at [3];
    logic        pend;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    n_acc = 0;
    pend  = 1'b0;
    for (int j = 0; j < 3; j++) acc_at[j] = 0;
    @(negedge ck);
    in_valid = 1'b1;
    in_data  = $urandom;
    bypass   = 1'b0;
    for (int i = 0; i < 140; i++) begin
      if (pend) begin
        pend = 1'b0;
        if (n_acc < 3) in_data = $urandom;
        else           in_valid = 1'b0;
      end
      // Write attempt while busy: must not reach the coefficient store.
      if (i == 10) begin
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 16'h4000;
      end
      if (i == 11) coef_we = 1'b0;
      if (out_valid) got_q.push_back(out_data);
      if (in_valid && in_ready && n_acc < 3) begin
        acc_at[n_acc] = i;
        n_acc++;
        exp_q.push_back(model_frame(in_data, 1'b0));
        pend = 1'b1;
      end
      @(negedge ck);
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc !== 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d required 3", n_acc);
    end
    checks++;
    if (acc_at[1] - acc_at[0] !== 35) begin
      errors++;
      $display("FAIL b2b_period1: got %0d required 35", acc_at[1] - acc_at[0]);
    end
    checks++;
    if (acc_at[2] - acc_at[1] !== 35) begin
      errors++;
      $display("FAIL b2b_period2: got %0d required 35", acc_at[2] - acc_at[1]);
    end
    checks++;
    if (got_q.size() !== 3) begin
      errors++;
      $display("FAIL b2b_outputs: got %0d required 3", got_q.size());
    end
    for (int j = 0; j < 3 && j < got_q.size() && j < exp_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %h required %h", j, got_q[j], exp_q[j]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bypass    = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    do_reset();
    test_identity();
    test_reset();
    test_impulse();
    test_saturation();
    test_random();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
